// File: rtl/wimax_phy_pkg.sv
// Shared types and constants for the WiMax PHY QPSK rate-1/2 block interleaver.
// intlv_perm is a plain arithmetic reference of the first permutation.
package wimax_phy_pkg;

  localparam int NCBPS_QPSK = 192;
  localparam int INTLV_D    = 16;
  localparam int INTLV_COLS = 12;

  typedef enum logic {RD_IDLE, RD_STREAM} intlv_rd_state_t;

  function automatic logic [7:0] intlv_perm(input logic [7:0] k);
    int unsigned m;
    m = INTLV_COLS * (int'(k) % INTLV_D) + int'(k) / INTLV_D;
    return m[7:0];
  endfunction

endpackage

// File: rtl/interleaver_perm_addr.sv
// First interleaver permutation m(k) = 12*(k mod 16) + k/16, built from shifts and adds.
module interleaver_perm_addr
  import wimax_phy_pkg::*;
(
  input  logic [7:0] k_i,
  output logic [7:0] m_o
);

  logic [7:0] col;
  logic [7:0] row;

  assign col = {4'b0000, k_i[3:0]};
  assign row = {4'b0000, k_i[7:4]};
  // 12*col = 8*col + 4*col; the largest result is 191, so 8 bits never overflow
  assign m_o = (col << 3) + (col << 2) + row;

endmodule

// File: rtl/interleaver_wimax_phy.sv
// Ping-pong block interleaver: bits are written at permuted addresses and read out sequentially.
// state     | meaning
// RD_IDLE   | no complete bank available, valid_out low
// RD_STREAM | streaming bank rd_bank to the modulator
module interleaver_wimax_phy
  import wimax_phy_pkg::*;
#(
  parameter int NCBPS = NCBPS_QPSK,
  parameter int D     = INTLV_D,
  parameter int NCPC  = 2
) (
  input  logic clk_100,
  input  logic reset_N,
  input  logic fec_encoder_output_valid,
  input  logic data_in,
  input  logic modulator_ready,
  output logic valid_out,
  output logic data_out,
  output logic ready_out
);

  if (NCPC != 2 || D != INTLV_D || NCBPS != NCBPS_QPSK) begin : g_cfg_check
    $error("interleaver_wimax_phy only supports QPSK: NCBPS=192, D=16, NCPC=2");
  end

  localparam logic [7:0] LAST = 8'(NCBPS - 1);

  logic [NCBPS-1:0] bank_q [2];
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [7:0]       wr_cnt_q, wr_cnt_d;
  logic [7:0]       rd_cnt_q, rd_cnt_d;
  intlv_rd_state_t  state_q, state_d;
  logic [7:0]       wr_addr;
  logic             wr_acc, rd_xfer;

  interleaver_perm_addr u_perm (
    .k_i (wr_cnt_q),
    .m_o (wr_addr)
  );

  assign ready_out = ~full_q[wr_bank_q];
  assign wr_acc    = fec_encoder_output_valid & ready_out;
  assign valid_out = (state_q == RD_STREAM);
  assign rd_xfer   = valid_out & modulator_ready;
  assign data_out  = valid_out ? bank_q[rd_bank_q][rd_cnt_q] : 1'b0;

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_bank_d = rd_bank_q;
    rd_cnt_d  = rd_cnt_q;
    state_d   = state_q;

    // set and clear can never hit the same bank: set needs full=0, clear needs full=1
    if (wr_acc) begin
      if (wr_cnt_q == LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + 8'd1;
      end
    end

    if (rd_xfer) begin
      if (rd_cnt_q == LAST) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_cnt_d          = '0;
      end else begin
        rd_cnt_d = rd_cnt_q + 8'd1;
      end
    end

    case (state_q)
      RD_IDLE:   if (full_q[rd_bank_q]) state_d = RD_STREAM;
      RD_STREAM: if (rd_xfer && rd_cnt_q == LAST && !full_q[~rd_bank_q]) state_d = RD_IDLE;
      default:   state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk_100 or negedge reset_N) begin
    if (!reset_N) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      state_q   <= RD_IDLE;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
      state_q   <= state_d;
    end
  end

  // bank contents carry no reset; full flags alone decide what is valid
  always_ff @(posedge clk_100) begin
    if (wr_acc) bank_q[wr_bank_q][wr_addr] <= data_in;
  end

endmodule

// File: tb/tb_interleaver_wimax_phy.sv
// Directed bench for interleaver_wimax_phy: one-hot permutation, sweep, streaming,
// backpressure, bursty handshake and mid-block reset.
module tb_interleaver_wimax_phy;
  import wimax_phy_pkg::*;

  logic clk_100 = 1'b0;
  logic reset_N = 1'b0;
  logic fec_valid = 1'b0;
  logic data_in = 1'b0;
  logic mod_ready = 1'b0;
  logic valid_out, data_out, ready_out;

  int n_cmp = 0;
  int n_err = 0;

  logic in_q[$];
  logic out_q[$];
  int in_idx;
  int cyc, acc192_cyc, first_vout_cyc, x192_cyc, rdy_rise_cyc;
  int stall_err, vgap, rlow;

  always #5 clk_100 = ~clk_100;

  interleaver_wimax_phy dut (
    .clk_100                  (clk_100),
    .reset_N                  (reset_N),
    .fec_encoder_output_valid (fec_valid),
    .data_in                  (data_in),
    .modulator_ready          (mod_ready),
    .valid_out                (valid_out),
    .data_out                 (data_out),
    .ready_out                (ready_out)
  );

  function automatic logic [191:0] model_block(input int b);
    logic [191:0] e;
    e = '0;
    for (int k = 0; k < 192; k++) e[intlv_perm(8'(k))] = in_q[b*192 + k];
    return e;
  endfunction

  function automatic logic [191:0] got_block(input int b);
    logic [191:0] g;
    g = '0;
    for (int p = 0; p < 192; p++)
      if (b*192 + p < out_q.size()) g[p] = out_q[b*192 + p];
    return g;
  endfunction

  task automatic do_reset();
    @(negedge clk_100);
    fec_valid = 1'b0; mod_ready = 1'b0; data_in = 1'b0;
    reset_N = 1'b0;
    @(negedge clk_100);
    reset_N = 1'b1;
    in_q.delete(); out_q.delete(); in_idx = 0;
  endtask

  // Cycle driver: drives at the negedge; outputs depend on state only, so they are stable there.
  task automatic run(input int vld_pct, input int rdy_pct, input int n_out, input int max_cyc);
    logic v, r, prev_stall, prev_dout, rdy_low_seen;
    cyc = 0; acc192_cyc = -1; first_vout_cyc = -1; x192_cyc = -1; rdy_rise_cyc = -1;
    stall_err = 0; vgap = 0; rlow = 0; prev_stall = 1'b0; prev_dout = 1'b0; rdy_low_seen = 1'b0;
    while (out_q.size() < n_out && cyc < max_cyc) begin
      @(negedge clk_100);
      v = (in_idx < in_q.size()) && ($urandom_range(0, 99) < vld_pct);
      r = ($urandom_range(0, 99) < rdy_pct);
      fec_valid = v;
      data_in   = v ? in_q[in_idx] : 1'b0;
      mod_ready = r;
      if (prev_stall && (valid_out !== 1'b1 || data_out !== prev_dout)) stall_err++;
      prev_stall = valid_out && !r;
      prev_dout  = data_out;
      if (!ready_out) rdy_low_seen = 1'b1;
      else if (rdy_low_seen && rdy_rise_cyc < 0) rdy_rise_cyc = cyc;
      if (!ready_out && in_idx >= 192 && in_idx < in_q.size()) rlow++;
      if (v && ready_out) begin
        in_idx++;
        if (in_idx == 192) acc192_cyc = cyc;
      end
      if (valid_out) begin
        if (first_vout_cyc < 0) first_vout_cyc = cyc;
        if (r) begin
          out_q.push_back(data_out);
          if (out_q.size() == 192) x192_cyc = cyc;
        end
      end else if (first_vout_cyc >= 0) begin
        vgap++;
      end
      cyc++;
    end
    @(posedge clk_100);
    #1;
    fec_valid = 1'b0; mod_ready = 1'b0; data_in = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_100);
    reset_N = 1'b1;
    #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset valid_out got=%b exp=0", valid_out); end
    n_cmp++; if (data_out !== 1'b0)  begin n_err++; $display("FAIL reset data_out got=%b exp=0", data_out); end
    n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL reset ready_out got=%b exp=1", ready_out); end
  endtask

  task automatic test_onehot();
    int ks[4] = '{1, 15, 16, 191};
    int ps[4] = '{12, 180, 1, 191};
    int ones, pos;
    for (int t = 0; t < 4; t++) begin
      do_reset();
      for (int i = 0; i < 192; i++) in_q.push_back(i == ks[t]);
      run(100, 100, 192, 600);
      ones = 0; pos = -1;
      foreach (out_q[p]) if (out_q[p] === 1'b1) begin ones++; if (pos < 0) pos = p; end
      n_cmp++; if (out_q.size() != 192) begin n_err++; $display("FAIL onehot_len k=%0d got=%0d exp=192", ks[t], out_q.size()); end
      n_cmp++; if (ones != 1) begin n_err++; $display("FAIL onehot_count k=%0d got=%0d exp=1", ks[t], ones); end
      n_cmp++; if (pos != ps[t]) begin n_err++; $display("FAIL onehot_pos k=%0d got=%0d exp=%0d", ks[t], pos, ps[t]); end
    end
  endtask

  task automatic test_sweep();
    int bad;
    logic [191:0] exp_v;
    do_reset();
    for (int j = 0; j < 192; j++)
      for (int k = 0; k < 192; k++) in_q.push_back(k == j);
    run(100, 100, 192*192, 40000);
    n_cmp++; if (out_q.size() != 192*192) begin n_err++; $display("FAIL sweep_len got=%0d exp=%0d", out_q.size(), 192*192); end
    n_cmp++; if (first_vout_cyc - acc192_cyc != 2) begin n_err++; $display("FAIL sweep_latency got=%0d exp=2", first_vout_cyc - acc192_cyc); end
    bad = 0;
    for (int j = 0; j < 192; j++) begin
      exp_v = '0;
      exp_v[intlv_perm(8'(j))] = 1'b1;
      if (got_block(j) !== exp_v) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL sweep_blocks bad_blocks=%0d exp=0", bad); end
  endtask

  task automatic test_streaming();
    do_reset();
    for (int i = 0; i < 768; i++) in_q.push_back(1'($urandom_range(0, 1)));
    run(100, 100, 768, 1200);
    n_cmp++; if (out_q.size() != 768) begin n_err++; $display("FAIL stream_len got=%0d exp=768", out_q.size()); end
    for (int b = 0; b < 4; b++) begin
      n_cmp++;
      if (got_block(b) !== model_block(b)) begin n_err++; $display("FAIL stream_block%0d got=%h exp=%h", b, got_block(b), model_block(b)); end
    end
    n_cmp++; if (rlow > 2) begin n_err++; $display("FAIL stream_ready_low got=%0d exp<=2", rlow); end
    n_cmp++; if (vgap > 2) begin n_err++; $display("FAIL stream_valid_gaps got=%0d exp<=2", vgap); end
    n_cmp++; if (cyc > 1000) begin n_err++; $display("FAIL stream_cycles got=%0d exp<=1000", cyc); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 400; i++) in_q.push_back(1'($urandom_range(0, 1)));
    run(100, 0, 1, 420);
    n_cmp++; if (in_idx != 384) begin n_err++; $display("FAIL bp_accepts got=%0d exp=384", in_idx); end
    n_cmp++; if (ready_out !== 1'b0) begin n_err++; $display("FAIL bp_ready_low got=%b exp=0", ready_out); end
    n_cmp++; if (out_q.size() != 0) begin n_err++; $display("FAIL bp_no_output got=%0d exp=0", out_q.size()); end
    run(100, 100, 384, 1000);
    n_cmp++; if (rdy_rise_cyc - x192_cyc != 1) begin n_err++; $display("FAIL bp_ready_rise got=%0d exp=1", rdy_rise_cyc - x192_cyc); end
    n_cmp++; if (vgap != 0) begin n_err++; $display("FAIL bp_no_bubble got=%0d exp=0", vgap); end
    n_cmp++; if (out_q.size() != 384) begin n_err++; $display("FAIL bp_len got=%0d exp=384", out_q.size()); end
    n_cmp++; if (in_idx != 400) begin n_err++; $display("FAIL bp_tail_accepts got=%0d exp=400", in_idx); end
    for (int b = 0; b < 2; b++) begin
      n_cmp++;
      if (got_block(b) !== model_block(b)) begin n_err++; $display("FAIL bp_block%0d got=%h exp=%h", b, got_block(b), model_block(b)); end
    end
  endtask

  task automatic test_bursty();
    do_reset();
    for (int i = 0; i < 576; i++) in_q.push_back(1'($urandom_range(0, 1)));
    run(60, 60, 576, 5000);
    n_cmp++; if (out_q.size() != 576) begin n_err++; $display("FAIL bursty_len got=%0d exp=576", out_q.size()); end
    n_cmp++; if (stall_err != 0) begin n_err++; $display("FAIL bursty_stall_stable got=%0d exp=0", stall_err); end
    for (int b = 0; b < 3; b++) begin
      n_cmp++;
      if (got_block(b) !== model_block(b)) begin n_err++; $display("FAIL bursty_block%0d got=%h exp=%h", b, got_block(b), model_block(b)); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 292; i++) in_q.push_back(1'($urandom_range(0, 1)));
    run(100, 0, 1, 292);
    n_cmp++; if (in_idx != 292) begin n_err++; $display("FAIL rmid_pre_accepts got=%0d exp=292", in_idx); end
    n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL rmid_pre_valid got=%b exp=1", valid_out); end
    @(negedge clk_100);
    reset_N = 1'b0;
    #1;
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rmid_valid got=%b exp=0", valid_out); end
    n_cmp++; if (data_out !== 1'b0)  begin n_err++; $display("FAIL rmid_data got=%b exp=0", data_out); end
    n_cmp++; if (ready_out !== 1'b1) begin n_err++; $display("FAIL rmid_ready got=%b exp=1", ready_out); end
    @(negedge clk_100);
    reset_N = 1'b1;
    in_q.delete(); out_q.delete(); in_idx = 0;
    for (int i = 0; i < 192; i++) in_q.push_back(1'($urandom_range(0, 1)));
    run(100, 100, 192, 600);
    n_cmp++; if (out_q.size() != 192) begin n_err++; $display("FAIL rmid_len got=%0d exp=192", out_q.size()); end
    n_cmp++;
    if (got_block(0) !== model_block(0)) begin n_err++; $display("FAIL rmid_block got=%h exp=%h", got_block(0), model_block(0)); end
  endtask

  initial begin
    test_reset();
    test_onehot();
    test_sweep();
    test_streaming();
    test_backpressure();
    test_bursty();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
